// File: rtl/uart_tx.sv
// UART transmitter: bytes enter a small FIFO through a valid/ready handshake and
// leave LSB-first on tx framed as start bit, DATA_BITS data bits, STOP_BITS stop bits.
module uart_tx #(
    parameter int CLK_DIV    = 1252,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [BAUD_W-1:0]      baud_reg, baud_next;
    logic [BIT_W-1:0]       bit_reg, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   tx_reg, tx_next;

    logic [DATA_BITS-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   last_data_bit;
    logic                   last_stop_bit;

    assign tx_ready      = (count_reg != CNT_W'(FIFO_DEPTH));
    assign fifo_empty    = (count_reg == '0);
    assign push          = tx_valid && tx_ready;
    assign fifo_head     = fifo_mem[rd_ptr_reg];
    assign bit_end       = (baud_reg == BAUD_W'(CLK_DIV - 1));
    assign last_data_bit = (bit_reg == BIT_W'(DATA_BITS - 1));
    assign last_stop_bit = (bit_reg == BIT_W'(STOP_BITS - 1));

    assign tx         = tx_reg;
    assign tx_busy    = (state_reg != IDLE);
    assign fifo_count = count_reg;

    // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;

        // Every state change happens on bit_end (or out of IDLE), so the counter restarts per bit.
        if (state_reg != IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (last_data_bit) begin
                        state_next = STOP;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!last_stop_bit) begin
                        bit_next = bit_reg + 1'b1;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        bit_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The line is registered from the next state so it changes on the same edge as the FSM.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule
